game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
- Parametrised, registered game-flow state machine for the space-invaders top level.
- Generalises the fixed four-stage controller to N stages, a lives counter, timed stage-won and respawn intervals, and pause handling.
- Drives the enable and reset strobes for the player and monster blocks, and reports stage, lives and end-of-game status to the HUD and drawing logic.

Parameters:
- NUM_STAGES, 4, number of stages; must be >= 1; stage_num counts 0..NUM_STAGES-1.
- NUM_LIVES, 3, lives at game start; must be >= 1.
- STAGE_DELAY_CYCLES, 50000000, cycles spent in STAGE_WON before advancing; must be >= 1.
- RESPAWN_DELAY_CYCLES, 25000000, cycles spent in LIFE_LOST before respawn; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_game  in  1  level; starts a game from IDLE, GAME_OVER or GAME_WON.
- pause  in  1  pause request (level; see Optional Feature).
- player_destroyed  in  1  player hit this cycle.
- win_stage  in  1  all monsters of the current stage destroyed.
- enable_player  out  1  player logic runs.
- enable_monsters  out  1  monster logic runs.
- resetN_player  out  1  active-low player re-init strobe.
- resetN_monsters  out  1  active-low monster re-init strobe.
- stage_num  out  STAGE_W=$clog2(NUM_STAGES) (min 1)  current stage index.
- lives_left  out  LIVES_W=$clog2(NUM_LIVES+1)  remaining lives.
- game_over  out  1  high in GAME_OVER.
- game_won  out  1  high in GAME_WON.
- fsm_state  out  3  current state encoding, for debug/HUD.

Behaviour:
- All outputs are registered (Moore). No combinational input-to-output path.
- Reset:
  - state=IDLE, stage_num=0, lives_left=NUM_LIVES, timer=0.
  - enable_*=0, resetN_*=0, game_over=0, game_won=0.
  - Reset during any state, including mid-timer, returns to these values on the next edge.
- States: IDLE, RUN, PAUSE, LIFE_LOST, STAGE_WON, GAME_OVER, GAME_WON.
- IDLE:
  - resetN_player and resetN_monsters held 0; enables 0.
  - start_game -> RUN on the next edge, with resetN_* released.
- RUN:
  - enable_player=1, enable_monsters=1.
  - Priority: pause > player_destroyed > win_stage.
  - pause -> PAUSE.
  - player_destroyed -> LIFE_LOST; lives_left decrements on the transition edge. If lives_left was 1, go directly to GAME_OVER with lives_left=0.
  - win_stage -> STAGE_WON.
  - player_destroyed and win_stage in the same cycle: the loss wins.
- PAUSE:
  - Enables 0; stage, lives and timer frozen.
  - Returns to RUN when pause is deasserted.
- LIFE_LOST:
  - Enables 0; pause ignored.
  - Timer counts 0..RESPAWN_DELAY_CYCLES-1, so exit occurs exactly RESPAWN_DELAY_CYCLES cycles after entry.
  - On exit, resetN_player=0 for exactly one cycle, then RUN.
- STAGE_WON:
  - Enables 0; pause ignored.
  - Timer runs STAGE_DELAY_CYCLES cycles.
  - If stage_num==NUM_STAGES-1: go to GAME_WON.
  - Otherwise: stage_num increments, resetN_monsters=0 for one cycle, then RUN.
  - stage_num never wraps.
- GAME_OVER / GAME_WON:
  - Sticky; enables 0; matching flag high.
  - start_game reloads stage_num=0 and lives_left=NUM_LIVES, pulses both resetN_* low for one cycle, then RUN.
- Timer:
  - Single counter, width $clog2(max(STAGE_DELAY_CYCLES, RESPAWN_DELAY_CYCLES)).
  - Cleared on every state change; counts only in LIFE_LOST and STAGE_WON.

Optional Feature:
- Macro: GAME_PAUSE_TOGGLE_EN.
- Defined:
  - pause is treated as a push-button. A registered rising-edge detector produces a one-cycle pause_pulse.
  - pause_pulse in RUN -> PAUSE; pause_pulse in PAUSE -> RUN.
  - Holding pause has no further effect.
  - The edge register is cleared by reset.
- Undefined: level behaviour as in Behaviour; no edge register is synthesised.

Decomposition:
- Package game_pkg:
  - typedef enum logic [2:0] game_state_t with IDLE=0, RUN=1, PAUSE=2, LIFE_LOST=3, STAGE_WON=4, GAME_OVER=5, GAME_WON=6.
  - Shared default delay constants.
- Sub-module game_delay_timer:
  - Parameter MAX_CYCLES; inputs clk, reset, clear, run, load_value.
  - Output done, high in the last counted cycle.
  - Instantiated once.

Test Plan:
- reset 3 cycles, start_game=1 for 1 cycle -> IDLE then RUN; enables=1; stage_num=0; lives_left=3; resetN_*=1.
- RUN, player_destroyed 1 cycle, RESPAWN_DELAY_CYCLES=4 -> lives_left=2; enables 0 for 4 cycles; resetN_player low 1 cycle; back in RUN.
- Three consecutive losses -> after the third, GAME_OVER, game_over=1, lives_left=0; later start_game -> RUN, lives_left=3, stage_num=0.
- win_stage in stages 0..2 with STAGE_DELAY_CYCLES=3 -> each advance takes 3 cycles, with one resetN_monsters pulse; fourth win_stage -> GAME_WON, game_won=1, stage_num stays 3.
- player_destroyed and win_stage asserted together in RUN -> LIFE_LOST and lives decrement; stage_num unchanged.
- pause held 10 cycles mid-RUN, and reset asserted mid-STAGE_WON -> PAUSE freezes all counters then resumes RUN; reset returns to IDLE with the reset values. With GAME_PAUSE_TOGGLE_EN, a held press enters PAUSE once and a second press resumes.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and default timing constants for the game-flow controller.
// The optional GAME_PAUSE_TOGGLE_EN build is handled in the top module.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSE     = 3'd2,
        LIFE_LOST = 3'd3,
        STAGE_WON = 3'd4,
        GAME_OVER = 3'd5,
        GAME_WON  = 3'd6
    } game_state_t;

    localparam int DEFAULT_STAGE_DELAY_CYCLES   = 50000000;
    localparam int DEFAULT_RESPAWN_DELAY_CYCLES = 25000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_delay_timer.sv
// Interval counter shared by the respawn and stage-won delays.
// done is high in the cycle whose count equals load_value, after which the count wraps to zero.
module game_delay_timer #(
    parameter int MAX_CYCLES = 1,
    parameter int WIDTH      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_end;

    assign w_at_end = (r_count == load_value);
    assign done     = run && w_at_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= w_at_end ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Registered game-flow FSM: stages, lives, respawn/stage delays and pause.
// Define GAME_PAUSE_TOGGLE_EN to treat pause as a push-button toggle instead of a level.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int NUM_STAGES           = 4,
    parameter int NUM_LIVES            = 3,
    parameter int STAGE_DELAY_CYCLES   = DEFAULT_STAGE_DELAY_CYCLES,
    parameter int RESPAWN_DELAY_CYCLES = DEFAULT_RESPAWN_DELAY_CYCLES,
    localparam int STAGE_W             = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int LIVES_W             = $clog2(NUM_LIVES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_game,
    input  logic               pause,
    input  logic               player_destroyed,
    input  logic               win_stage,
    output logic               enable_player,
    output logic               enable_monsters,
    output logic               resetN_player,
    output logic               resetN_monsters,
    output logic [STAGE_W-1:0] stage_num,
    output logic [LIVES_W-1:0] lives_left,
    output logic               game_over,
    output logic               game_won,
    output logic [2:0]         fsm_state
);

    localparam int TIMER_MAX = max_int(STAGE_DELAY_CYCLES, RESPAWN_DELAY_CYCLES);
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [STAGE_W-1:0] LAST_STAGE   = STAGE_W'(NUM_STAGES - 1);
    localparam logic [LIVES_W-1:0] FULL_LIVES   = LIVES_W'(NUM_LIVES);
    localparam logic [TIMER_W-1:0] STAGE_LOAD   = TIMER_W'(STAGE_DELAY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_DELAY_CYCLES - 1);

    game_state_t        r_state;
    logic [STAGE_W-1:0] r_stage_num;
    logic [LIVES_W-1:0] r_lives_left;
    logic               r_enable;
    logic               r_resetN_player;
    logic               r_resetN_monsters;
    logic               r_game_over;
    logic               r_game_won;

    logic               w_pause_enter;
    logic               w_pause_exit;
    logic               w_timer_run;
    logic               w_timer_done;
    logic [TIMER_W-1:0] w_timer_load;

`ifdef GAME_PAUSE_TOGGLE_EN
    logic r_pause_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pause_d <= 1'b0;
        end else begin
            r_pause_d <= pause;
        end
    end

    assign w_pause_enter = pause && !r_pause_d;
    assign w_pause_exit  = w_pause_enter;
`else
    assign w_pause_enter = pause;
    assign w_pause_exit  = !pause;
`endif

    // Timer idles at zero outside the two delay states, so every entry starts a fresh interval.
    assign w_timer_run  = (r_state == LIFE_LOST) || (r_state == STAGE_WON);
    assign w_timer_load = (r_state == LIFE_LOST) ? RESPAWN_LOAD : STAGE_LOAD;

    game_delay_timer #(
        .MAX_CYCLES (TIMER_MAX),
        .WIDTH      (TIMER_W)
    ) u_delay_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!w_timer_run),
        .run        (w_timer_run),
        .load_value (w_timer_load),
        .done       (w_timer_done)
    );

    // Re-init strobes are issued on the edge that enters RUN and released by RUN one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= IDLE;
            r_stage_num       <= '0;
            r_lives_left      <= FULL_LIVES;
            r_enable          <= 1'b0;
            r_resetN_player   <= 1'b0;
            r_resetN_monsters <= 1'b0;
            r_game_over       <= 1'b0;
            r_game_won        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_game) begin
                        r_state           <= RUN;
                        r_enable          <= 1'b1;
                        r_resetN_player   <= 1'b1;
                        r_resetN_monsters <= 1'b1;
                    end
                end
                RUN: begin
                    r_resetN_player   <= 1'b1;
                    r_resetN_monsters <= 1'b1;
                    if (w_pause_enter) begin
                        r_state  <= PAUSE;
                        r_enable <= 1'b0;
                    end else if (player_destroyed) begin
                        r_enable <= 1'b0;
                        if (r_lives_left == LIVES_W'(1)) begin
                            r_state      <= GAME_OVER;
                            r_lives_left <= '0;
                            r_game_over  <= 1'b1;
                        end else begin
                            r_state      <= LIFE_LOST;
                            r_lives_left <= r_lives_left - LIVES_W'(1);
                        end
                    end else if (win_stage) begin
                        r_state  <= STAGE_WON;
                        r_enable <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (w_pause_exit) begin
                        r_state  <= RUN;
                        r_enable <= 1'b1;
                    end
                end
                LIFE_LOST: begin
                    if (w_timer_done) begin
                        r_state         <= RUN;
                        r_enable        <= 1'b1;
                        r_resetN_player <= 1'b0;
                    end
                end
                STAGE_WON: begin
                    if (w_timer_done) begin
                        if (r_stage_num == LAST_STAGE) begin
                            r_state    <= GAME_WON;
                            r_game_won <= 1'b1;
                        end else begin
                            r_state           <= RUN;
                            r_enable          <= 1'b1;
                            r_stage_num       <= r_stage_num + STAGE_W'(1);
                            r_resetN_monsters <= 1'b0;
                        end
                    end
                end
                GAME_OVER, GAME_WON: begin
                    if (start_game) begin
                        r_state           <= RUN;
                        r_enable          <= 1'b1;
                        r_stage_num       <= '0;
                        r_lives_left      <= FULL_LIVES;
                        r_resetN_player   <= 1'b0;
                        r_resetN_monsters <= 1'b0;
                        r_game_over       <= 1'b0;
                        r_game_won        <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    assign enable_player   = r_enable;
    assign enable_monsters = r_enable;
    assign resetN_player   = r_resetN_player;
    assign resetN_monsters = r_resetN_monsters;
    assign stage_num       = r_stage_num;
    assign lives_left      = r_lives_left;
    assign game_over       = r_game_over;
    assign game_won        = r_game_won;
    assign fsm_state       = r_state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed, table-driven bench for game_flow_controller with short delays (stage 3, respawn 4).
// Honours GAME_PAUSE_TOGGLE_EN for the pause sequence.
module tb_game_flow_controller;
    import game_pkg::*;

    logic       clk;
    logic       reset;
    logic       start_game;
    logic       pause;
    logic       player_destroyed;
    logic       win_stage;
    logic       enable_player;
    logic       enable_monsters;
    logic       resetN_player;
    logic       resetN_monsters;
    logic [1:0] stage_num;
    logic [1:0] lives_left;
    logic       game_over;
    logic       game_won;
    logic [2:0] fsm_state;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic        s;
        logic        p;
        logic        d;
        logic        w;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    game_flow_controller #(
        .NUM_STAGES           (4),
        .NUM_LIVES            (3),
        .STAGE_DELAY_CYCLES   (3),
        .RESPAWN_DELAY_CYCLES (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start_game       (start_game),
        .pause            (pause),
        .player_destroyed (player_destroyed),
        .win_stage        (win_stage),
        .enable_player    (enable_player),
        .enable_monsters  (enable_monsters),
        .resetN_player    (resetN_player),
        .resetN_monsters  (resetN_monsters),
        .stage_num        (stage_num),
        .lives_left       (lives_left),
        .game_over        (game_over),
        .game_won         (game_won),
        .fsm_state        (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ex(input logic [2:0] st, input logic en, input logic rp,
                                       input logic rm, input logic [1:0] stg,
                                       input logic [1:0] lv, input logic go, input logic gw);
        return {st, en, en, rp, rm, stg, lv, go, gw};
    endfunction

    task automatic addVec(input logic s, input logic p, input logic d, input logic w,
                          input logic [12:0] exp);
        vecs.push_back('{s, p, d, w, exp});
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic d, input logic w);
        start_game       = s;
        pause            = p;
        player_destroyed = d;
        win_stage        = w;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {fsm_state, enable_player, enable_monsters, resetN_player, resetN_monsters,
               stage_num, lives_left, game_over, game_won};
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got state/enP/enM/rnP/rnM/stage/lives/go/gw=%b required %b",
                     name, act, exp);
        end
    endtask

    initial begin
        reset            = 1'b1;
        start_game       = 1'b0;
        pause            = 1'b0;
        player_destroyed = 1'b0;
        win_stage        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", ex(IDLE, 0, 0, 0, 2'd0, 2'd3, 0, 0));
        reset = 1'b0;

        // Start, respawn, double-hit priority, game over, restart, four stages, game won.
        addVec(0, 0, 0, 0, ex(IDLE,      0, 0, 0, 2'd0, 2'd3, 0, 0));
        addVec(1, 0, 0, 0, ex(RUN,       1, 1, 1, 2'd0, 2'd3, 0, 0));
        addVec(1, 0, 0, 0, ex(RUN,       1, 1, 1, 2'd0, 2'd3, 0, 0));
        addVec(0, 0, 1, 0, ex(LIFE_LOST, 0, 1, 1, 2'd0, 2'd2, 0, 0));
        for (int i = 0; i < 3; i++)
            addVec(0, 0, 0, 0, ex(LIFE_LOST, 0, 1, 1, 2'd0, 2'd2, 0, 0));
        addVec(0, 0, 0, 0, ex(RUN,       1, 0, 1, 2'd0, 2'd2, 0, 0));
        addVec(0, 0, 0, 0, ex(RUN,       1, 1, 1, 2'd0, 2'd2, 0, 0));
        addVec(0, 0, 1, 1, ex(LIFE_LOST, 0, 1, 1, 2'd0, 2'd1, 0, 0));
        for (int i = 0; i < 3; i++)
            addVec(0, 0, 0, 0, ex(LIFE_LOST, 0, 1, 1, 2'd0, 2'd1, 0, 0));
        addVec(0, 0, 0, 0, ex(RUN,       1, 0, 1, 2'd0, 2'd1, 0, 0));
        addVec(0, 0, 0, 0, ex(RUN,       1, 1, 1, 2'd0, 2'd1, 0, 0));
        addVec(0, 0, 1, 0, ex(GAME_OVER, 0, 1, 1, 2'd0, 2'd0, 1, 0));
        addVec(0, 0, 0, 0, ex(GAME_OVER, 0, 1, 1, 2'd0, 2'd0, 1, 0));
        addVec(1, 0, 0, 0, ex(RUN,       1, 0, 0, 2'd0, 2'd3, 0, 0));
        addVec(0, 0, 0, 0, ex(RUN,       1, 1, 1, 2'd0, 2'd3, 0, 0));
        for (int stg = 0; stg < 4; stg++) begin
            for (int i = 0; i < 3; i++)
                addVec(0, 0, 0, (i == 0), ex(STAGE_WON, 0, 1, 1, 2'(stg), 2'd3, 0, 0));
            if (stg < 3)
                addVec(0, 0, 0, 0, ex(RUN, 1, 1, 0, 2'(stg + 1), 2'd3, 0, 0));
        end
        addVec(0, 0, 0, 0, ex(GAME_WON,  0, 1, 1, 2'd3, 2'd3, 0, 1));
        addVec(0, 0, 0, 0, ex(GAME_WON,  0, 1, 1, 2'd3, 2'd3, 0, 1));
        addVec(0, 0, 0, 1, ex(GAME_WON,  0, 1, 1, 2'd3, 2'd3, 0, 1));
        addVec(1, 0, 0, 0, ex(RUN,       1, 0, 0, 2'd0, 2'd3, 0, 0));
        addVec(0, 0, 0, 0, ex(RUN,       1, 1, 1, 2'd0, 2'd3, 0, 0));
        addVec(0, 0, 1, 0, ex(LIFE_LOST, 0, 1, 1, 2'd0, 2'd2, 0, 0));
        for (int i = 0; i < 3; i++)
            addVec(0, 1, 0, 0, ex(LIFE_LOST, 0, 1, 1, 2'd0, 2'd2, 0, 0));
        addVec(0, 0, 0, 0, ex(RUN,       1, 0, 1, 2'd0, 2'd2, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].s, vecs[i].p, vecs[i].d, vecs[i].w);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Pause held for ten cycles while hits and wins arrive: everything stays frozen.
        applyStimulus(0, 0, 0, 0);
        checkOutput("runBeforePause", ex(RUN, 1, 1, 1, 2'd0, 2'd2, 0, 0));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, (i % 2 == 0), (i % 2 == 1));
            checkOutput($sformatf("pauseHeld%0d", i), ex(PAUSE, 0, 1, 1, 2'd0, 2'd2, 0, 0));
        end
`ifdef GAME_PAUSE_TOGGLE_EN
        applyStimulus(0, 0, 0, 0);
        checkOutput("pauseReleased", ex(PAUSE, 0, 1, 1, 2'd0, 2'd2, 0, 0));
        applyStimulus(0, 1, 0, 0);
        checkOutput("pauseSecondPress", ex(RUN, 1, 1, 1, 2'd0, 2'd2, 0, 0));
        applyStimulus(0, 1, 0, 0);
        checkOutput("pauseStillHeld", ex(RUN, 1, 1, 1, 2'd0, 2'd2, 0, 0));
        applyStimulus(0, 0, 0, 0);
`else
        applyStimulus(0, 0, 0, 0);
        checkOutput("pauseReleased", ex(RUN, 1, 1, 1, 2'd0, 2'd2, 0, 0));
`endif

        // Reset in the middle of a stage-won interval, then a clean stage advance.
        applyStimulus(0, 0, 0, 1);
        checkOutput("stageWonEnter", ex(STAGE_WON, 0, 1, 1, 2'd0, 2'd2, 0, 0));
        applyStimulus(0, 0, 0, 0);
        checkOutput("stageWonMid", ex(STAGE_WON, 0, 1, 1, 2'd0, 2'd2, 0, 0));
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("resetMidStage", ex(IDLE, 0, 0, 0, 2'd0, 2'd3, 0, 0));
        reset = 1'b0;
        applyStimulus(1, 0, 0, 0);
        checkOutput("restartAfterReset", ex(RUN, 1, 1, 1, 2'd0, 2'd3, 0, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, (i == 0));
            checkOutput($sformatf("stageWonFresh%0d", i), ex(STAGE_WON, 0, 1, 1, 2'd0, 2'd3, 0, 0));
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("stageAdvance", ex(RUN, 1, 1, 0, 2'd1, 2'd3, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
